mips_load_store_unit: RTL and testbench



---
 rtl/mips_load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_mips_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_load_store_unit.sv
// Load/store unit between the MIPS memory stage and the word-wide data memory.
// Handles big-endian lane selection, sign/zero extension, sub-word RMW and alignment errors.
module mips_load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] write_data,
  output logic        sig_mem_read,
  output logic        sig_mem_write,
  input  logic [31:0] read_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ST_RD = 3'd2,
    S_ST_WR = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [31:0] addr_q, wdata_q;

  logic        req_fire;
  logic        op_legal, op_aligned;
  logic [31:0] mem_address_nxt, write_data_nxt, resp_rdata_nxt;
  logic        sig_mem_read_nxt, sig_mem_write_nxt, resp_err_nxt;

  // Big-endian lane select plus extension; op[2] set means zero-extend.
  function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    unique case (op[1:0])
      2'b00:   r = {{24{b[7] & ~op[2]}}, b};
      2'b01:   r = {{16{h[15] & ~op[2]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic [31:0] old,
                                              input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    unique case (size)
      2'b00: begin
        unique case (off)
          2'd0:    r[31:24] = wd[7:0];
          2'd1:    r[23:16] = wd[7:0];
          2'd2:    r[15:8]  = wd[7:0];
          default: r[7:0]   = wd[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[15:0]  = wd[15:0];
        else        r[31:16] = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign req_fire   = req_valid && req_ready;

  always_comb begin
    op_legal   = 1'b0;
    op_aligned = 1'b0;
    unique case (req_op[2:0])
      3'b000, 3'b001, 3'b011, 3'b100, 3'b101: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
    unique case (req_op[1:0])
      2'b00:   op_aligned = 1'b1;
      2'b01:   op_aligned = ~req_addr[0];
      2'b11:   op_aligned = (req_addr[1:0] == 2'b00);
      default: op_aligned = 1'b0;
    endcase
  end

  // Memory-side outputs are computed for the next state and registered.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt         = state;
    mem_address_nxt   = 32'd0;
    write_data_nxt    = 32'd0;
    sig_mem_read_nxt  = 1'b0;
    sig_mem_write_nxt = 1'b0;
    resp_rdata_nxt    = resp_rdata;
    resp_err_nxt      = resp_err;
    unique case (state)
      S_IDLE: begin
        if (req_fire) begin
          if (!(op_legal && op_aligned)) begin
            state_nxt      = S_RESP;
            resp_err_nxt   = 1'b1;
            resp_rdata_nxt = 32'd0;
          end else if (!req_op[3]) begin
            state_nxt        = S_LOAD;
            sig_mem_read_nxt = 1'b1;
            mem_address_nxt  = {2'b00, req_addr[31:2]};
          end else if (req_op[1:0] == 2'b11) begin
            state_nxt         = S_ST_WR;
            sig_mem_write_nxt = 1'b1;
            mem_address_nxt   = {2'b00, req_addr[31:2]};
            write_data_nxt    = req_wdata;
          end else begin
            state_nxt        = S_ST_RD;
            sig_mem_read_nxt = 1'b1;
            mem_address_nxt  = {2'b00, req_addr[31:2]};
          end
        end
      end
      S_LOAD: begin
        state_nxt      = S_RESP;
        resp_rdata_nxt = load_extend(op_q[2:0], addr_q[1:0], read_data);
        resp_err_nxt   = 1'b0;
      end
      S_ST_RD: begin
        state_nxt         = S_ST_WR;
        sig_mem_write_nxt = 1'b1;
        mem_address_nxt   = {2'b00, addr_q[31:2]};
        write_data_nxt    = store_merge(op_q[1:0], addr_q[1:0], read_data, wdata_q);
      end
      S_ST_WR: begin
        state_nxt      = S_RESP;
        resp_rdata_nxt = 32'd0;
        resp_err_nxt   = 1'b0;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= 4'd0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      mem_address   <= 32'd0;
      write_data    <= 32'd0;
      sig_mem_read  <= 1'b0;
      sig_mem_write <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_err      <= 1'b0;
    end else begin
      state         <= state_nxt;
      mem_address   <= mem_address_nxt;
      write_data    <= write_data_nxt;
      sig_mem_read  <= sig_mem_read_nxt;
      sig_mem_write <= sig_mem_write_nxt;
      resp_rdata    <= resp_rdata_nxt;
      resp_err      <= resp_err_nxt;
      if (req_fire) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed self-checking bench for mips_load_store_unit with a small word memory attached.
module tb_mips_load_store_unit;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1011;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, write_data, read_data;
  logic        sig_mem_read, sig_mem_write;

  logic [31:0] mem [0:15];

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;
  logic [31:0] rd_addr, wr_addr, wr_data;
  int          got_lat;
  logic [31:0] got_rdata;
  logic        got_err;

  mips_load_store_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_address   (mem_address),
    .write_data    (write_data),
    .sig_mem_read  (sig_mem_read),
    .sig_mem_write (sig_mem_write),
    .read_data     (read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign read_data = mem[mem_address[3:0]];

  always @(posedge clk) begin
    if (sig_mem_write) mem[mem_address[3:0]] <= write_data;
  end

  always @(negedge clk) begin
    if (sig_mem_read) begin
      rd_cnt  = rd_cnt + 1;
      rd_addr = mem_address;
    end
    if (sig_mem_write) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = mem_address;
      wr_data = write_data;
    end
    if (sig_mem_read && sig_mem_write) both_cnt = both_cnt + 1;
    if (resp_valid) resp_cnt = resp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; result latched in got_*; latency counted in cycles after the accept edge.
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    rd_cnt   = 0;
    wr_cnt   = 0;
    got_lat  = -1;
    got_rdata = 32'hxxxxxxxx;
    got_err  = 1'bx;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid = 1'b0;
        req_op    = OP_SW;
        req_addr  = 32'h4;
        req_wdata = 32'hFFFF_FFFF;
      end
      if (resp_valid) begin
        got_lat   = n;
        got_rdata = resp_rdata;
        got_err   = resp_err;
        break;
      end
    end
  endtask

  task automatic load_chk(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] exp);
    do_req(op, addr, 32'h0);
    check({tag, "_lat"}, got_lat, 32'd2);
    check({tag, "_rdata"}, got_rdata, exp);
    check({tag, "_err"}, {31'd0, got_err}, 32'd0);
    check({tag, "_rdcnt"}, rd_cnt, 32'd1);
  endtask

  task automatic err_chk(input string tag, input logic [3:0] op, input logic [31:0] addr);
    do_req(op, addr, 32'h0000_FFFF);
    check({tag, "_lat"}, got_lat, 32'd1);
    check({tag, "_err"}, {31'd0, got_err}, 32'd1);
    check({tag, "_rdata"}, got_rdata, 32'd0);
    check({tag, "_rdcnt"}, rd_cnt, 32'd0);
    check({tag, "_wrcnt"}, wr_cnt, 32'd0);
  endtask

  logic [3:0]  b2b_op  [3];
  logic [31:0] b2b_adr [3];
  logic [31:0] b2b_exp [3];
  int          acc_cyc [3];
  int          n_acc, n_resp;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[1] = 32'h7F80_0001;
    mem[2] = 32'h80FF_0000;
    mem[3] = 32'h1122_3344;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_req_ready",   {31'd0, req_ready},     32'd1);
    check("rst_resp_valid",  {31'd0, resp_valid},    32'd0);
    check("rst_resp_err",    {31'd0, resp_err},      32'd0);
    check("rst_resp_rdata",  resp_rdata,             32'd0);
    check("rst_mem_address", mem_address,            32'd0);
    check("rst_write_data",  write_data,             32'd0);
    check("rst_mem_read",    {31'd0, sig_mem_read},  32'd0);
    check("rst_mem_write",   {31'd0, sig_mem_write}, 32'd0);

    load_chk("lw4", OP_LW, 32'd4, 32'h7F80_0001);
    check("lw4_rdaddr", rd_addr, 32'd1);
    check("lw4_wrcnt", wr_cnt, 32'd0);
    load_chk("lb4",  OP_LB,  32'd4, 32'h0000_007F);
    load_chk("lb5",  OP_LB,  32'd5, 32'hFFFF_FF80);
    load_chk("lb7",  OP_LB,  32'd7, 32'h0000_0001);
    load_chk("lh6",  OP_LH,  32'd6, 32'h0000_0001);
    load_chk("lh4",  OP_LH,  32'd4, 32'h0000_7F80);
    load_chk("lb8",  OP_LB,  32'd8, 32'hFFFF_FF80);
    load_chk("lbu8", OP_LBU, 32'd8, 32'h0000_0080);
    load_chk("lh8",  OP_LH,  32'd8, 32'hFFFF_80FF);
    load_chk("lhu8", OP_LHU, 32'd8, 32'h0000_80FF);

    do_req(OP_SB, 32'd5, 32'h0000_00AB);
    check("sb5_lat",    got_lat, 32'd3);
    check("sb5_err",    {31'd0, got_err}, 32'd0);
    check("sb5_rdata",  got_rdata, 32'd0);
    check("sb5_rdcnt",  rd_cnt, 32'd1);
    check("sb5_wrcnt",  wr_cnt, 32'd1);
    check("sb5_wraddr", wr_addr, 32'd1);
    check("sb5_wdata",  wr_data, 32'h7FAB_0001);
    load_chk("lw4_after_sb", OP_LW, 32'd4, 32'h7FAB_0001);

    do_req(OP_SH, 32'd10, 32'h1234_CAFE);
    check("sh10_lat",   got_lat, 32'd3);
    check("sh10_wdata", wr_data, 32'h80FF_CAFE);
    load_chk("lw8_after_sh", OP_LW, 32'd8, 32'h80FF_CAFE);

    do_req(OP_SW, 32'd16, 32'h1234_5678);
    check("sw16_lat",   got_lat, 32'd2);
    check("sw16_rdcnt", rd_cnt, 32'd0);
    check("sw16_wrcnt", wr_cnt, 32'd1);
    check("sw16_mem",   mem[4], 32'h1234_5678);

    err_chk("sh5_misalign", OP_SH, 32'd5);
    check("sh5_mem_kept", mem[1], 32'h7FAB_0001);
    err_chk("lw6_misalign", OP_LW, 32'd6);
    err_chk("illegal_op",   4'b0010, 32'd0);

    // Abort a word store while its write strobe is up.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_SW;
    req_addr  = 32'd12;
    req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_wr_before", {31'd0, sig_mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    resp_cnt = 0;
    check("abort_wr_drop",    {31'd0, sig_mem_write}, 32'd0);
    check("abort_ready",      {31'd0, req_ready},     32'd1);
    check("abort_write_data", write_data,             32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_resp", resp_cnt, 32'd0);
    check("abort_mem_kept", mem[3], 32'h1122_3344);
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);

    // Back-to-back loads with req_valid held high and junk stores presented while busy.
    b2b_op[0] = OP_LW;  b2b_adr[0] = 32'd4;  b2b_exp[0] = 32'h7FAB_0001;
    b2b_op[1] = OP_LBU; b2b_adr[1] = 32'd11; b2b_exp[1] = 32'h0000_00FE;
    b2b_op[2] = OP_LH;  b2b_adr[2] = 32'd8;  b2b_exp[2] = 32'hFFFF_80FF;
    n_acc  = 0;
    n_resp = 0;
    @(negedge clk);
    for (int c = 0; c < 40 && n_resp < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (resp_valid) begin
        check($sformatf("b2b_rdata%0d", n_resp), resp_rdata, b2b_exp[n_resp]);
        n_resp++;
      end
      if (req_ready && n_acc < 3) begin
        req_valid = 1'b1;
        req_op    = b2b_op[n_acc];
        req_addr  = b2b_adr[n_acc];
        req_wdata = 32'd0;
        acc_cyc[n_acc] = c;
        n_acc++;
      end else if (n_resp == 3) begin
        req_valid = 1'b0;
      end else begin
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h4 ^ 32'(c & 3);
        req_wdata = 32'(c);
      end
    end
    req_valid = 1'b0;
    check("b2b_accepts", n_acc, 32'd3);
    check("b2b_resps", n_resp, 32'd3);
    check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 32'd3);
    check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 32'd3);
    repeat (3) @(negedge clk);
    check("b2b_mem_kept", mem[1], 32'h7FAB_0001);
    check("never_rd_and_wr", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
